rom_read_arbiter: RTL
=====================

# rom_read_arbiter

Two-port round-robin read arbiter that shares one synchronous ROM between two requesters. The ROM has a single registered read port with 1-cycle latency. The arbiter serialises requests onto the ROM address bus, waits out the ROM read latency, and returns the fetched word to the requester that issued it. It sits directly in front of the `rom` block.

## Interface
- `ADDR_W`, default 2: ROM address width.
- `DATA_W`, default 4: ROM word width.

- `clk` in 1: single clock, rising edge; same clock as the ROM.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1: requester 0 has a read pending.
- `req0_addr` in ADDR_W: requester 0 read address.
- `req0_ready` out 1: requester 0 request accepted this cycle.
- `req1_valid` in 1: requester 1 has a read pending.
- `req1_addr` in ADDR_W: requester 1 read address.
- `req1_ready` out 1: requester 1 request accepted this cycle.
- `rsp0_valid` out 1: one-cycle pulse; `rsp0_data` holds the word for requester 0.
- `rsp0_data` out DATA_W: read data for requester 0.
- `rsp1_valid` out 1: one-cycle pulse for requester 1.
- `rsp1_data` out DATA_W: read data for requester 1.
- `rom_addr` out ADDR_W: registered address driven to the ROM.
- `rom_data` in DATA_W: ROM registered data output.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- FSM with three states: IDLE, ADDR, DATA.
  - IDLE -> ADDR when any `reqN_valid` is high.
  - ADDR -> DATA unconditionally.
  - DATA -> IDLE unconditionally.
- Request handshake:
  - A request transfers on a rising edge where `reqN_valid && reqN_ready`.
  - The requester holds `valid` and `addr` stable until `ready` is seen.
  - `ready` is combinational and is asserted only in IDLE, for the granted port only.
  - At most one `ready` is high in any cycle.
- Arbitration:
  - Register `last` records the most recently granted port.
  - If exactly one port is valid, that port is granted.
  - If both are valid, the port != `last` is granted.
  - `last` updates on each accepted request.
- Datapath:
  - On the accept edge, `rom_addr` <= granted address and `owner` <= granted port.
  - `rom_addr` holds its value until the next accept.
- Response:
  - On the edge leaving DATA, `rsp<owner>_data` <= `rom_data`, and `rsp<owner>_valid` pulses high for exactly one cycle.
  - The other port's `rsp_data` is unchanged.
  - There is no response backpressure.
- `rsp_data` holds its value between responses.
- A request dropped before its `ready` is not remembered.
- Reset values:
  - state IDLE, `rom_addr` 0, `owner` 0, `last` 1 (port 0 wins the first tie).
  - All `rsp_valid` 0, all `rsp_data` 0.
  - `busy` 0; both `ready` outputs reflect IDLE arbitration immediately after reset.
- Reset mid-operation: the in-flight read is abandoned and no response pulse is produced. All registers return to their reset values asynchronously.

## Timing
- Accept edge E0: `rom_addr` is updated.
- Edge E1 (end of ADDR): the ROM registers `ROM[rom_addr]`.
- Edge E2 (end of DATA): the response is captured, and `rspN_valid` is high in the cycle after E2.
- Latency from accept edge to `rsp_valid` high is 2 cycles.
- Throughput is one request per 3 cycles. The next accept can occur at E3 at the earliest, because `ready` reasserts in the cycle after E2, concurrent with `rsp_valid`.
- Continuous demand from both ports alternates grants 0,1,0,1… so neither port waits more than one transaction.
- Address width wraps naturally and no range check is done; all 2^ADDR_W addresses are legal.

## Test plan
- **Single read:** after reset, ROM holds {0011,1000,1111,0110}. Drive `req0_valid=1`, `addr=2` -> `req0_ready` high in the same cycle, `rsp0_valid` pulses 2 cycles after accept with `rsp0_data=1111`, and `rsp1_valid` stays 0.
- **Simultaneous requests:** `req0` at `addr=1` and `req1` at `addr=3` from reset -> port 0 granted first (`rsp0_data=1000`), then port 1 accepted 3 cycles later (`rsp1_data=0110`).
- **Fairness:** hold both valid for 6 transactions with `addr0=0`, `addr1=2` -> grant order 0,1,0,1,0,1, responses 0011 and 1111 alternating, with one response every 3 cycles.
- **Back-to-back on one port:** `req1` reads 0,1,2,3 in sequence -> `rsp1_data` is 0011, 1000, 1111, 0110, and accepts are spaced exactly 3 cycles apart.
- **Reset mid-read:** assert `rst_n=0` in the ADDR state -> no `rsp_valid` pulse, `busy=0`, `rom_addr=0`, `rsp_data=0`. After release, a `req1`-only read of `addr=3` returns 0110.
- **Ready gating:** keep `req1` valid while port 0 is in flight -> `req1_ready` stays 0 during ADDR and DATA and asserts in the cycle after DATA.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rom_read_arbiter: round-robin arbiter sharing one 1-cycle-latency ROM between two requesters
module rom_read_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, owner_q, owner_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d, rsp1_data_q, rsp1_data_d;
  logic grant, accept;
  // grant the only valid port, or on a tie the port not served last; accept only in IDLE
  always_comb begin
    grant = (req0_valid && req1_valid) ? ~last_q : req1_valid;
    accept = (state_q == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end
  // sequence IDLE->ADDR->DATA, capture address/owner on accept and ROM word leaving DATA
  always_comb begin
    state_d = (state_q == IDLE) ? (accept ? ADDR : IDLE) : (state_q == ADDR) ? DATA : IDLE;
    last_d = accept ? grant : last_q;
    owner_d = accept ? grant : owner_q;
    rom_addr_d = accept ? (grant ? req1_addr : req0_addr) : rom_addr_q;
    rsp0_valid_d = (state_q == DATA) && !owner_q;
    rsp1_valid_d = (state_q == DATA) && owner_q;
    rsp0_data_d = rsp0_valid_d ? rom_data : rsp0_data_q;
    rsp1_data_d = rsp1_valid_d ? rom_data : rsp1_data_q;
  end
  // state registers; reset abandons any in-flight read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      owner_q <= 1'b0;
      rom_addr_q <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      owner_q <= owner_d;
      rom_addr_q <= rom_addr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end
  assign rom_addr = rom_addr_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data = rsp0_data_q;
  assign rsp1_data = rsp1_data_q;
  assign busy = state_q != IDLE;
endmodule
